// File: rtl/disp_owner_arb.sv
// Display ownership arbiter: fixed-priority selection of one of four digit sources,
// with a minimum hold time and a one-cycle blank on every change of owner.
module disp_owner_arb #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_req,
    input  logic [95:0] i_dig,
    output logic [23:0] o_dig,
    output logic [3:0]  o_grant,
    output logic        o_switch
);

    // state | meaning
    // IDLE  | no requester, display blanked
    // BLANK | one-cycle blank while the pending owner takes over
    // OWN   | owner's digits shown, hold counter running
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BLANK = 2'b01,
        S_OWN   = 2'b10
    } state_t;

    localparam logic [23:0]      BLANK_DIG = 24'hFFFFFF;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYC - 1);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_owner, w_owner_nx;
    logic [3:0]       r_grant, w_grant_nx;
    logic [23:0]      r_dig, w_dig_nx;
    logic             r_switch, w_switch_nx;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nx;

    logic [1:0]       w_hi;
    logic [23:0]      w_src_dig;

    always_comb begin
        w_hi = 2'd0;
        if (i_req[3])      w_hi = 2'd3;
        else if (i_req[2]) w_hi = 2'd2;
        else if (i_req[1]) w_hi = 2'd1;
    end

    always_comb begin
        case (r_owner)
            2'd0:    w_src_dig = i_dig[23:0];
            2'd1:    w_src_dig = i_dig[47:24];
            2'd2:    w_src_dig = i_dig[71:48];
            default: w_src_dig = i_dig[95:72];
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_grant_nx  = r_grant;
        w_dig_nx    = r_dig;
        w_switch_nx = 1'b0;
        w_hold_nx   = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_grant_nx = 4'b0000;
                w_dig_nx   = BLANK_DIG;
                if (i_req != 4'b0000) begin
                    w_state_nx  = S_BLANK;
                    w_owner_nx  = w_hi;
                    w_grant_nx  = 4'b0001 << w_hi;
                    w_switch_nx = 1'b1;
                end
            end
            S_BLANK: begin
                w_state_nx = S_OWN;
                w_dig_nx   = w_src_dig;
                w_hold_nx  = HOLD_INIT;
            end
            S_OWN: begin
                w_dig_nx  = w_src_dig;
                w_hold_nx = (r_hold_cnt == '0) ? '0 : r_hold_cnt - 1'b1;
                if (i_req == 4'b0000) begin
                    w_state_nx = S_IDLE;
                    w_dig_nx   = BLANK_DIG;
                    w_grant_nx = 4'b0000;
                end else if (!i_req[r_owner] ||
                             (w_hi == 2'd3 && r_owner != 2'd3) ||
                             (w_hi > r_owner && r_hold_cnt == '0)) begin
                    // owner dropped, ring preemption, or expired hold: hi always wins
                    w_state_nx  = S_BLANK;
                    w_owner_nx  = w_hi;
                    w_grant_nx  = 4'b0001 << w_hi;
                    w_switch_nx = 1'b1;
                    w_dig_nx    = BLANK_DIG;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_owner_nx = 2'd0;
                w_grant_nx = 4'b0000;
                w_dig_nx   = BLANK_DIG;
                w_hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 2'd0;
            r_grant    <= 4'b0000;
            r_dig      <= BLANK_DIG;
            r_switch   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_owner    <= w_owner_nx;
            r_grant    <= w_grant_nx;
            r_dig      <= w_dig_nx;
            r_switch   <= w_switch_nx;
            r_hold_cnt <= w_hold_nx;
        end
    end

    assign o_dig    = r_dig;
    assign o_grant  = r_grant;
    assign o_switch = r_switch;

endmodule

// File: tb/tb_disp_owner_arb.sv
// Directed bench for disp_owner_arb with HOLD_CYC=4; expected values hand-computed per cycle.
module tb_disp_owner_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  i_req;
    logic [95:0] i_dig;
    logic [23:0] o_dig;
    logic [3:0]  o_grant;
    logic        o_switch;

    int n_tests = 0;
    int n_fail  = 0;

    disp_owner_arb #(.HOLD_CYC(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_dig    (i_dig),
        .o_dig    (o_dig),
        .o_grant  (o_grant),
        .o_switch (o_switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] e_dig,
                       input logic [3:0] e_grant, input logic e_sw);
        n_tests++;
        assert (o_dig === e_dig) else begin
            n_fail++;
            $error("FAIL %s o_dig observed=%h expected=%h", tag, o_dig, e_dig);
        end
        n_tests++;
        assert (o_grant === e_grant) else begin
            n_fail++;
            $error("FAIL %s o_grant observed=%b expected=%b", tag, o_grant, e_grant);
        end
        n_tests++;
        assert (o_switch === e_sw) else begin
            n_fail++;
            $error("FAIL %s o_switch observed=%b expected=%b", tag, o_switch, e_sw);
        end
    endtask

    initial begin
        rst   = 1'b1;
        i_req = 4'b0000;
        i_dig = {24'h333333, 24'h222222, 24'h111111, 24'h123456};

        // reset and idle
        tick(); tick();
        chk("rst_hold", 24'hFFFFFF, 4'b0000, 1'b0);
        rst = 1'b0;
        tick(); chk("idle1", 24'hFFFFFF, 4'b0000, 1'b0);
        tick(); chk("idle2", 24'hFFFFFF, 4'b0000, 1'b0);

        // time source acquires display
        i_req = 4'b0001;
        tick(); chk("t0_blank", 24'hFFFFFF, 4'b0001, 1'b1);
        tick(); chk("t0_own", 24'h123456, 4'b0001, 1'b0);

        // first OWN cycle: stopwatch raised, digits change; hold keeps owner 0
        i_req = 4'b0101;
        i_dig[23:0] = 24'h123457;
        tick(); chk("hold1", 24'h123457, 4'b0001, 1'b0);
        tick(); chk("hold2", 24'h123457, 4'b0001, 1'b0);
        tick(); chk("hold3", 24'h123457, 4'b0001, 1'b0);
        tick(); chk("sw_blank", 24'hFFFFFF, 4'b0100, 1'b1);
        tick(); chk("sw_own", 24'h222222, 4'b0100, 1'b0);

        // owner drops and alarm view asserted in the same cycle
        i_req = 4'b0011;
        tick(); chk("drop_blank", 24'hFFFFFF, 4'b0010, 1'b1);
        tick(); chk("av_own", 24'h111111, 4'b0010, 1'b0);

        // ring bypasses hold in owner 1's first OWN cycle
        i_req = 4'b1011;
        tick(); chk("ring_blank", 24'hFFFFFF, 4'b1000, 1'b1);
        tick(); chk("ring_own", 24'h333333, 4'b1000, 1'b0);

        // lower requests ignored by ring owner; digit update follows
        i_req = 4'b1111;
        i_dig[95:72] = 24'h334455;
        tick(); chk("ring_keep", 24'h334455, 4'b1000, 1'b0);

        // all requests dropped -> idle
        i_req = 4'b0000;
        tick(); chk("to_idle", 24'hFFFFFF, 4'b0000, 1'b0);
        tick(); chk("idle3", 24'hFFFFFF, 4'b0000, 1'b0);

        // pending request dropped during BLANK: OWN still entered, then rule a
        i_req = 4'b0100;
        tick(); chk("pend_blank", 24'hFFFFFF, 4'b0100, 1'b1);
        i_req = 4'b0001;
        tick(); chk("pend_own", 24'h222222, 4'b0100, 1'b0);
        tick(); chk("pend_reblank", 24'hFFFFFF, 4'b0001, 1'b1);
        tick(); chk("pend_t0_own", 24'h123457, 4'b0001, 1'b0);

        // ring takes over, then reset mid-OWN
        i_req = 4'b1001;
        tick(); chk("ring2_blank", 24'hFFFFFF, 4'b1000, 1'b1);
        tick(); chk("ring2_own", 24'h334455, 4'b1000, 1'b0);
        rst   = 1'b1;
        i_req = 4'b1000;
        tick(); chk("rst_mid_own", 24'hFFFFFF, 4'b0000, 1'b0);
        rst = 1'b0;
        tick(); chk("post_rst_blank", 24'hFFFFFF, 4'b1000, 1'b1);
        tick(); chk("post_rst_own", 24'h334455, 4'b1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
